machine_trap_unit: RTL and testbench
====================================

MACHINE_TRAP_UNIT -- requirements
Module: machine_trap_unit

Interface
REQ-001 SHALL have parameter N, default 64, meaning XLEN and the width of all CSRs and PCs.
REQ-002 SHALL have parameter NUM_IRQ, default 16, meaning the interrupt line count (1..16, bounded by the mip/mie low bits).
REQ-003 SHALL have parameter TRAP_BASE, default 0, meaning the mtvec reset value.
REQ-004 SHALL have port clk  input  1  the single clock, all state on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port exceptSignal  input  16  synchronous exception requests, bit index = cause code.
REQ-007 SHALL have port interruptSignal  input  NUM_IRQ  asynchronous level interrupt lines, bit index = cause code.
REQ-008 SHALL have port PC_E  input  N  PC of the instruction raising the exception.
REQ-009 SHALL have port tval  input  N  fault value for mtval.
REQ-010 SHALL have port mret  input  1  an mret is committing this cycle.
REQ-011 SHALL have ports csr_we  input  1, csr_op  input  2 (01 write, 10 set, 11 clear), csr_addr  input  12, csr_wdata  input  N: the CSR access port.
REQ-012 SHALL have ports csr_rdata  output  N and csr_illegal  output  1: combinational read data and a flag for an unmapped address.
REQ-013 SHALL have ports redirect  output  1, PC_Trap  output  N and mIE  output  1: the fetch redirect, its target, and mstatus.MIE.

Function
REQ-014 SHALL map mstatus 0x300, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343 and mip 0x344 (read-only); every other address SHALL assert csr_illegal and return zero.
REQ-015 SHALL implement only mstatus bits MIE[3], MPIE[7] and MPP[12:11], with MPP hardwired to 2'b11 and all other bits reading zero.
REQ-016 SHALL force mepc[1:0] to zero; mtvec[1:0] SHALL be the mode (00 direct, 01 vectored), and writes of 1x SHALL keep the old mode.
REQ-017 SHALL pass interruptSignal through a two-flop synchronizer into mip, so mip reflects a line 2 cycles after it changes.
REQ-018 SHALL run an FSM with states IDLE, TRAP and RETURN, all three leaving to IDLE after 1 cycle.
REQ-019 SHALL, in IDLE, take a trap if any exceptSignal bit is set (lowest set index wins).
REQ-020 SHALL otherwise, in IDLE, take an interrupt if mstatus.MIE and |(mip & mie) hold (highest set index wins).
REQ-021 SHALL otherwise, in IDLE, honour mret.
REQ-022 SHALL, on the edge that takes a trap: set mepc<=PC_E, mcause<={irq,cause} (bit N-1 = irq), mtval<=tval (zero for interrupts), MPIE<=MIE, MIE<=0, and state<=TRAP.
REQ-023 SHALL, in TRAP, hold redirect=1 with PC_Trap = {mtvec[N-1:2],2'b00}, plus 4*cause only when the mode is vectored and the trap is an interrupt.
REQ-024 SHALL, on the edge that accepts mret: set MIE<=MPIE, MPIE<=1 and state<=RETURN; in RETURN redirect=1 and PC_Trap=mepc.
REQ-025 SHALL ignore exceptSignal, interrupts and mret while in TRAP or RETURN, because the pipeline is being flushed.
REQ-026 SHALL drop a CSR write that coincides with a trap or mret acceptance, or that arrives in TRAP/RETURN.
REQ-027 SHALL otherwise apply csr_we on the next edge with set/clear as OR/AND-NOT against the current value.
REQ-028 SHALL ignore writes to mip or to illegal addresses with no state change.
REQ-029 SHALL keep redirect and PC_Trap low/zero in IDLE, giving a trap/mret-to-redirect latency of exactly 1 cycle.

Reset
REQ-030 SHALL, while reset is low, immediately force state=IDLE, mtvec=TRAP_BASE, and all other CSRs, synchronizer flops and outputs to 0 (except MPP=11).
REQ-031 SHALL, on reset assertion mid-TRAP or mid-RETURN, abandon the redirect with no partial CSR update retained.

Structure
REQ-032 SHALL take the CSR address constants, the csr_op encoding and the FSM state enum from a shared package trap_pkg.
REQ-033 SHALL place the two-flop synchronizer in a sub-module irq_sync, parametrised by width, with the same clk/reset.

Verification
REQ-034 SHALL cover: exceptSignal=16'h0004 with PC_E=0x100, mtvec=0x800 -> next cycle redirect=1, PC_Trap=0x800, mcause=2, mepc=0x100, MIE=0.
REQ-035 SHALL cover: MIE=1, mie=0x880, vectored mtvec=0x801, interruptSignal[11] rises -> 2 cycles later the trap is taken, then PC_Trap=0x82C and mcause={1,11}.
REQ-036 SHALL cover: exceptSignal=0x0006 together with a pending enabled interrupt and mret -> cause 1 exception only, mret ignored.
REQ-037 SHALL cover: mepc=0x204, MPIE=1, mret pulse -> next cycle redirect=1, PC_Trap=0x204, MIE=1.
REQ-038 SHALL cover: a csr_we write of mscratch=0xAA coinciding with a trap -> mscratch stays 0; a set on mie with 0x8 in IDLE -> mie bit 3 set; a read of 0x7C0 -> csr_illegal=1.
REQ-039 SHALL cover: reset low during TRAP -> redirect drops immediately, mtvec=TRAP_BASE, mepc=0.

Source files
------------

// File: rtl/trap_pkg.sv
// Shared definitions for the machine-mode trap unit: CSR map, access ops,
// FSM states and the cause-priority helpers.
package trap_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MIP      = 12'h344;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;

  typedef enum logic [1:0] {
    CSR_OP_NONE  = 2'b00,
    CSR_OP_WRITE = 2'b01,
    CSR_OP_SET   = 2'b10,
    CSR_OP_CLEAR = 2'b11
  } csr_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TRAP   = 2'd1,
    ST_RETURN = 2'd2
  } trap_state_e;

  // Exceptions: the lowest index is the highest priority.
  function automatic logic [3:0] lowest_set16(input logic [15:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  // Interrupts: the highest index is the highest priority.
  function automatic logic [3:0] highest_set16(input logic [15:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/irq_sync.sv
// Two-flop synchronizer bringing the asynchronous interrupt lines into clk.
module irq_sync #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] i_async,
  output logic [W-1:0] o_sync
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  for (genvar gi = 0; gi < W; gi++) begin : g_bit
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_meta[gi] <= 1'b0;
        r_sync[gi] <= 1'b0;
      end else begin
        r_meta[gi] <= i_async[gi];
        r_sync[gi] <= r_meta[gi];
      end
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/machine_trap_unit.sv
// Machine-mode trap unit: M-mode CSRs, exception/interrupt entry, mret return
// and a one-cycle fetch redirect toward the handler or the saved mepc.
module machine_trap_unit
  import trap_pkg::*;
#(
  parameter int             N         = 64,
  parameter int             NUM_IRQ   = 16,
  parameter logic [N-1:0]   TRAP_BASE = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [15:0]        exceptSignal,
  input  logic [NUM_IRQ-1:0] interruptSignal,
  input  logic [N-1:0]       PC_E,
  input  logic [N-1:0]       tval,
  input  logic               mret,
  input  logic               csr_we,
  input  logic [1:0]         csr_op,
  input  logic [11:0]        csr_addr,
  input  logic [N-1:0]       csr_wdata,
  output logic [N-1:0]       csr_rdata,
  output logic               csr_illegal,
  output logic               redirect,
  output logic [N-1:0]       PC_Trap,
  output logic               mIE
);

  trap_state_e        r_state;
  logic               r_mstatus_mie;
  logic               r_mstatus_mpie;
  logic [NUM_IRQ-1:0] r_mie;
  logic [N-1:0]       r_mtvec;
  logic [N-1:0]       r_mscratch;
  logic [N-1:0]       r_mepc;
  logic [N-1:0]       r_mcause;
  logic [N-1:0]       r_mtval;

  logic [NUM_IRQ-1:0] w_mip;
  logic [15:0]        w_pending16;
  logic [N-1:0]       w_mstatus;
  logic [N-1:0]       w_csr_new;
  logic [N-1:0]       w_vec_off;
  logic [3:0]         w_trap_cause;
  logic               w_idle;
  logic               w_exc_any;
  logic               w_take_exc;
  logic               w_take_irq;
  logic               w_take_trap;
  logic               w_take_mret;
  logic               w_csr_apply;
  csr_op_e            w_op;

  irq_sync #(.W(NUM_IRQ)) u_irq_sync (
    .clk     (clk),
    .reset   (reset),
    .i_async (interruptSignal),
    .o_sync  (w_mip)
  );

  assign w_op        = csr_op_e'(csr_op);
  assign w_idle      = (r_state == ST_IDLE);
  assign w_pending16 = 16'(w_mip & r_mie);
  assign w_exc_any   = |exceptSignal;

  // Exceptions outrank interrupts; mret only wins when neither is taken.
  assign w_take_exc   = w_idle && w_exc_any;
  assign w_take_irq   = w_idle && !w_exc_any && r_mstatus_mie && (|w_pending16);
  assign w_take_trap  = w_take_exc || w_take_irq;
  assign w_take_mret  = w_idle && !w_take_trap && mret;
  assign w_trap_cause = w_exc_any ? lowest_set16(exceptSignal) : highest_set16(w_pending16);

  always_comb begin
    w_mstatus                   = '0;
    w_mstatus[MSTATUS_MIE_BIT]  = r_mstatus_mie;
    w_mstatus[MSTATUS_MPIE_BIT] = r_mstatus_mpie;
    w_mstatus[12:11]            = 2'b11;
  end

  always_comb begin
    csr_rdata   = '0;
    csr_illegal = 1'b0;
    case (csr_addr)
      CSR_MSTATUS:  csr_rdata = w_mstatus;
      CSR_MIE:      csr_rdata = N'(r_mie);
      CSR_MTVEC:    csr_rdata = r_mtvec;
      CSR_MSCRATCH: csr_rdata = r_mscratch;
      CSR_MEPC:     csr_rdata = r_mepc;
      CSR_MCAUSE:   csr_rdata = r_mcause;
      CSR_MTVAL:    csr_rdata = r_mtval;
      CSR_MIP:      csr_rdata = N'(w_mip);
      default:      csr_illegal = 1'b1;
    endcase
  end

  always_comb begin
    case (w_op)
      CSR_OP_WRITE: w_csr_new = csr_wdata;
      CSR_OP_SET:   w_csr_new = csr_rdata | csr_wdata;
      CSR_OP_CLEAR: w_csr_new = csr_rdata & ~csr_wdata;
      default:      w_csr_new = csr_rdata;
    endcase
  end

  // Software writes lose to trap/mret bookkeeping and are frozen during flush.
  assign w_csr_apply = csr_we && w_idle && !w_take_trap && !w_take_mret &&
                       (w_op != CSR_OP_NONE) && !csr_illegal && (csr_addr != CSR_MIP);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_take_trap)      r_state <= ST_TRAP;
          else if (w_take_mret) r_state <= ST_RETURN;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mstatus_mie  <= 1'b0;
      r_mstatus_mpie <= 1'b0;
      r_mie          <= '0;
      r_mtvec        <= TRAP_BASE;
      r_mscratch     <= '0;
      r_mepc         <= '0;
      r_mcause       <= '0;
      r_mtval        <= '0;
    end else if (w_take_trap) begin
      r_mepc         <= PC_E & {{(N-2){1'b1}}, 2'b00};
      r_mcause       <= {w_take_irq, {(N-5){1'b0}}, w_trap_cause};
      r_mtval        <= w_take_irq ? '0 : tval;
      r_mstatus_mpie <= r_mstatus_mie;
      r_mstatus_mie  <= 1'b0;
    end else if (w_take_mret) begin
      r_mstatus_mie  <= r_mstatus_mpie;
      r_mstatus_mpie <= 1'b1;
    end else if (w_csr_apply) begin
      case (csr_addr)
        CSR_MSTATUS: begin
          r_mstatus_mie  <= w_csr_new[MSTATUS_MIE_BIT];
          r_mstatus_mpie <= w_csr_new[MSTATUS_MPIE_BIT];
        end
        CSR_MIE:      r_mie      <= w_csr_new[NUM_IRQ-1:0];
        // Reserved modes (1x) leave the current mode untouched.
        CSR_MTVEC:    r_mtvec    <= {w_csr_new[N-1:2],
                                     w_csr_new[1] ? r_mtvec[1:0] : w_csr_new[1:0]};
        CSR_MSCRATCH: r_mscratch <= w_csr_new;
        CSR_MEPC:     r_mepc     <= w_csr_new & {{(N-2){1'b1}}, 2'b00};
        CSR_MCAUSE:   r_mcause   <= w_csr_new;
        CSR_MTVAL:    r_mtval    <= w_csr_new;
        default: ;
      endcase
    end
  end

  assign w_vec_off = N'({r_mcause[3:0], 2'b00});

  always_comb begin
    redirect = 1'b0;
    PC_Trap  = '0;
    case (r_state)
      ST_TRAP: begin
        redirect = 1'b1;
        PC_Trap  = {r_mtvec[N-1:2], 2'b00} +
                   (((r_mtvec[1:0] == 2'b01) && r_mcause[N-1]) ? w_vec_off : '0);
      end
      ST_RETURN: begin
        redirect = 1'b1;
        PC_Trap  = r_mepc;
      end
      default: ;
    endcase
  end

  assign mIE = r_mstatus_mie;

endmodule

// File: tb/tb_machine_trap_unit.sv
// Directed bench for machine_trap_unit with hand-computed expectations.
module tb_machine_trap_unit;
  import trap_pkg::*;

  localparam int           N       = 64;
  localparam int           NUM_IRQ = 16;
  localparam logic [N-1:0] BASE    = 64'h1000;

  logic               clk = 1'b0;
  logic               reset;
  logic [15:0]        exceptSignal;
  logic [NUM_IRQ-1:0] interruptSignal;
  logic [N-1:0]       PC_E;
  logic [N-1:0]       tval;
  logic               mret;
  logic               csr_we;
  logic [1:0]         csr_op;
  logic [11:0]        csr_addr;
  logic [N-1:0]       csr_wdata;
  logic [N-1:0]       csr_rdata;
  logic               csr_illegal;
  logic               redirect;
  logic [N-1:0]       PC_Trap;
  logic               mIE;

  int n_checks = 0;
  int n_pass   = 0;

  machine_trap_unit #(.N(N), .NUM_IRQ(NUM_IRQ), .TRAP_BASE(BASE)) dut (
    .clk             (clk),
    .reset           (reset),
    .exceptSignal    (exceptSignal),
    .interruptSignal (interruptSignal),
    .PC_E            (PC_E),
    .tval            (tval),
    .mret            (mret),
    .csr_we          (csr_we),
    .csr_op          (csr_op),
    .csr_addr        (csr_addr),
    .csr_wdata       (csr_wdata),
    .csr_rdata       (csr_rdata),
    .csr_illegal     (csr_illegal),
    .redirect        (redirect),
    .PC_Trap         (PC_Trap),
    .mIE             (mIE)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("pass %s got=%h", tag, got);
    end else begin
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_csr(input string tag, input logic [11:0] addr, input logic [63:0] exp);
    csr_addr = addr;
    #1;
    check(tag, csr_rdata, exp);
  endtask

  task automatic csr_wr(input logic [11:0] addr, input logic [1:0] op, input logic [63:0] data);
    csr_we    = 1'b1;
    csr_addr  = addr;
    csr_op    = op;
    csr_wdata = data;
    tick();
    csr_we    = 1'b0;
    csr_op    = CSR_OP_NONE;
  endtask

  initial begin
    reset = 1'b0; exceptSignal = '0; interruptSignal = '0; PC_E = '0; tval = '0;
    mret = 1'b0; csr_we = 1'b0; csr_op = CSR_OP_NONE; csr_addr = CSR_MSTATUS; csr_wdata = '0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_redirect", 64'(redirect), 64'd0);
    check("rst_pctrap", PC_Trap, 64'd0);
    check("rst_mie_out", 64'(mIE), 64'd0);
    check_csr("rst_mtvec", CSR_MTVEC, BASE);
    check_csr("rst_mstatus", CSR_MSTATUS, 64'h1800);
    reset = 1'b1;
    tick();

    // Address decode
    csr_addr = 12'h7C0;
    #1;
    check("illegal_flag", 64'(csr_illegal), 64'd1);
    check("illegal_data", csr_rdata, 64'd0);
    csr_addr = CSR_MSCRATCH;
    #1;
    check("legal_flag", 64'(csr_illegal), 64'd0);

    // Synchronous exception, with a coincident mscratch write that must drop
    csr_wr(CSR_MTVEC, CSR_OP_WRITE, 64'h800);
    check_csr("mtvec_wr", CSR_MTVEC, 64'h800);
    csr_wr(CSR_MSTATUS, CSR_OP_SET, 64'h8);
    check("mie_set", 64'(mIE), 64'd1);
    exceptSignal = 16'h0004; PC_E = 64'h100; tval = 64'hDEAD;
    csr_we = 1'b1; csr_op = CSR_OP_WRITE; csr_addr = CSR_MSCRATCH; csr_wdata = 64'hAA;
    #1;
    check("exc_pre_redirect", 64'(redirect), 64'd0);
    tick();
    exceptSignal = '0; csr_we = 1'b0; csr_op = CSR_OP_NONE;
    check("exc_redirect", 64'(redirect), 64'd1);
    check("exc_pctrap", PC_Trap, 64'h800);
    check("exc_mie_out", 64'(mIE), 64'd0);
    check_csr("exc_mcause", CSR_MCAUSE, 64'd2);
    check_csr("exc_mepc", CSR_MEPC, 64'h100);
    check_csr("exc_mtval", CSR_MTVAL, 64'hDEAD);
    check_csr("exc_mscratch", CSR_MSCRATCH, 64'd0);
    check_csr("exc_mstatus", CSR_MSTATUS, 64'h1880);
    tick();
    check("exc_done", 64'(redirect), 64'd0);
    check("exc_done_pc", PC_Trap, 64'd0);

    // CSR ops: set, write, clear, reserved mtvec mode
    csr_wr(CSR_MIE, CSR_OP_SET, 64'h8);
    check_csr("mie_set8", CSR_MIE, 64'h8);
    csr_wr(CSR_MIE, CSR_OP_WRITE, 64'h880);
    check_csr("mie_wr", CSR_MIE, 64'h880);
    csr_wr(CSR_MSCRATCH, CSR_OP_WRITE, 64'hFF);
    csr_wr(CSR_MSCRATCH, CSR_OP_CLEAR, 64'h0F);
    check_csr("mscratch_clr", CSR_MSCRATCH, 64'hF0);
    csr_wr(CSR_MTVEC, CSR_OP_WRITE, 64'h801);
    check_csr("mtvec_vec", CSR_MTVEC, 64'h801);
    csr_wr(CSR_MTVEC, CSR_OP_WRITE, 64'h802);
    check_csr("mtvec_rsvd", CSR_MTVEC, 64'h801);
    csr_wr(CSR_MIP, CSR_OP_WRITE, 64'hFFFF);
    check_csr("mip_ro", CSR_MIP, 64'd0);

    // Vectored interrupt on line 11
    csr_wr(CSR_MSTATUS, CSR_OP_SET, 64'h8);
    PC_E = 64'h300; tval = 64'h77;
    interruptSignal = 16'h0800;
    tick();
    check_csr("irq_mip_1", CSR_MIP, 64'd0);
    tick();
    check_csr("irq_mip_2", CSR_MIP, 64'h800);
    check("irq_not_yet", 64'(redirect), 64'd0);
    tick();
    interruptSignal = '0;
    check("irq_redirect", 64'(redirect), 64'd1);
    check("irq_pctrap", PC_Trap, 64'h82C);
    check_csr("irq_mcause", CSR_MCAUSE, 64'h8000_0000_0000_000B);
    check_csr("irq_mepc", CSR_MEPC, 64'h300);
    check_csr("irq_mtval", CSR_MTVAL, 64'd0);
    check("irq_mie_out", 64'(mIE), 64'd0);
    tick();
    check("irq_done", 64'(redirect), 64'd0);
    tick();
    tick();

    // Exception, enabled interrupt and mret all at once; mret held through TRAP
    csr_wr(CSR_MSTATUS, CSR_OP_SET, 64'h8);
    interruptSignal = 16'h0080;
    tick();
    tick();
    check_csr("mix_mip", CSR_MIP, 64'h80);
    exceptSignal = 16'h0006; mret = 1'b1; PC_E = 64'h400; tval = 64'h55;
    tick();
    exceptSignal = '0;
    check("mix_redirect", 64'(redirect), 64'd1);
    check("mix_pctrap", PC_Trap, 64'h800);
    check_csr("mix_mcause", CSR_MCAUSE, 64'd1);
    check_csr("mix_mtval", CSR_MTVAL, 64'h55);
    check_csr("mix_mepc", CSR_MEPC, 64'h400);
    tick();
    mret = 1'b0;
    check("mix_mret_ign", 64'(redirect), 64'd0);
    check_csr("mix_mstatus", CSR_MSTATUS, 64'h1880);
    interruptSignal = '0;
    tick();
    tick();
    tick();

    // mret returns to mepc and restores MIE from MPIE
    csr_wr(CSR_MEPC, CSR_OP_WRITE, 64'h207);
    check_csr("mepc_align", CSR_MEPC, 64'h204);
    mret = 1'b1;
    tick();
    mret = 1'b0;
    check("ret_redirect", 64'(redirect), 64'd1);
    check("ret_pctrap", PC_Trap, 64'h204);
    check("ret_mie_out", 64'(mIE), 64'd1);
    check_csr("ret_mstatus", CSR_MSTATUS, 64'h1888);
    tick();
    check("ret_done", 64'(redirect), 64'd0);

    // Reset asserted while in TRAP
    exceptSignal = 16'h0001; PC_E = 64'h500;
    tick();
    exceptSignal = '0;
    check("rtrap_redirect", 64'(redirect), 64'd1);
    check("rtrap_pctrap", PC_Trap, 64'h800);
    reset = 1'b0;
    #1;
    check("rtrap_drop", 64'(redirect), 64'd0);
    check("rtrap_pc0", PC_Trap, 64'd0);
    check_csr("rtrap_mtvec", CSR_MTVEC, BASE);
    check_csr("rtrap_mepc", CSR_MEPC, 64'd0);
    check_csr("rtrap_mcause", CSR_MCAUSE, 64'd0);
    check("rtrap_mie_out", 64'(mIE), 64'd0);
    tick();
    reset = 1'b1;
    tick();
    check("post_rst_idle", 64'(redirect), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
